// File: rtl/spi_regfile_periph.sv
// SPI mode-0 target exposing a generic register bank with read-back on cipo.
// All SPI pins are oversampled in the clk domain; malformed frames are counted, never committed.
module spi_regfile_periph #(
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sclk,
    input  logic                         ncs,
    input  logic                         copi,
    output logic                         cipo,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_out,
    output logic                         wr_pulse,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic [7:0]                   frame_err_cnt
);

    localparam int unsigned FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);
    localparam int unsigned IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned FLUSH_W = $clog2(SYNC_STAGES + 2);

    localparam logic [CNT_W-1:0]   CNT_ADDR  = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(FRAME_W);
    localparam logic [FLUSH_W-1:0] FLUSH_MAX = FLUSH_W'(SYNC_STAGES + 1);

    typedef enum logic [2:0] {StWaitHi, StIdle, StCmd, StData, StDone} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] ncs_sync_q, ncs_sync_d;
    logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
    logic                   sclk_dly_q, sclk_dly_d;
    logic                   ncs_dly_q, ncs_dly_d;
    logic [FLUSH_W-1:0]     flush_q, flush_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [FRAME_W-1:0]     shift_q, shift_d;
    logic [DATA_W-1:0]      shadow_q, shadow_d;
    logic                   first_q, first_d;
    logic                   overrun_q, overrun_d;
    logic                   cipo_q, cipo_d;
    logic                   cipo_oe_q, cipo_oe_d;
    logic                   wr_pulse_q, wr_pulse_d;
    logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
    logic [7:0]             err_q, err_d;
    logic [DATA_W-1:0]      regs_q [NUM_REGS];
    logic [DATA_W-1:0]      regs_d [NUM_REGS];

    logic                   sclk_s, ncs_s, copi_s;
    logic                   sclk_rise, sclk_fall, ncs_rise, ncs_fall;
    logic [FRAME_W-1:0]     shift_nxt;
    logic [ADDR_W-1:0]      addr_nxt, fr_addr;
    logic [DATA_W-1:0]      fr_data, shadow_shl;
    logic                   fr_rw;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return 64'(a) < 64'(NUM_REGS);
    endfunction

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
    assign copi_s    = copi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_dly_q;
    assign sclk_fall = ~sclk_s & sclk_dly_q;
    assign ncs_rise  = ncs_s & ~ncs_dly_q;
    assign ncs_fall  = ~ncs_s & ncs_dly_q;

    assign shift_nxt  = {shift_q[FRAME_W-2:0], copi_s};
    assign addr_nxt   = shift_nxt[ADDR_W-1:0];
    assign fr_rw      = shift_q[FRAME_W-1];
    assign fr_addr    = shift_q[DATA_W +: ADDR_W];
    assign fr_data    = shift_q[DATA_W-1:0];
    assign shadow_shl = shadow_q << 1;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0], ncs};
        copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], copi};
        sclk_dly_d  = sclk_s;
        ncs_dly_d   = ncs_s;
        state_d     = state_q;
        flush_d     = flush_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        shadow_d    = shadow_q;
        first_d     = first_q;
        overrun_d   = overrun_q;
        cipo_d      = cipo_q;
        cipo_oe_d   = cipo_oe_q;
        wr_pulse_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        err_d       = err_q;
        regs_d      = regs_q;

        case (state_q)
            // Wait until the sync chain holds real pin samples, then for ncs to be high.
            StWaitHi: begin
                if (flush_q != FLUSH_MAX) begin
                    flush_d = flush_q + FLUSH_W'(1);
                end else if (ncs_s) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (ncs_fall) begin
                    state_d   = StCmd;
                    cnt_d     = '0;
                    overrun_d = 1'b0;
                    first_d   = 1'b0;
                    cipo_d    = 1'b0;
                    cipo_oe_d = 1'b1;
                end
            end
            default: begin
                if (ncs_rise) begin
                    state_d   = StIdle;
                    cipo_d    = 1'b0;
                    cipo_oe_d = 1'b0;
                    if (cnt_q == CNT_FULL && !overrun_q) begin
                        if (fr_rw && addr_ok(fr_addr)) begin
                            regs_d[fr_addr[IDX_W-1:0]] = fr_data;
                            wr_addr_d  = fr_addr;
                            wr_pulse_d = 1'b1;
                        end
                    end else if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                end else begin
                    case (state_q)
                        StCmd: begin
                            if (sclk_rise) begin
                                shift_d = shift_nxt;
                                cnt_d   = cnt_q + CNT_W'(1);
                                if (cnt_q == CNT_ADDR) begin
                                    shadow_d = addr_ok(addr_nxt) ?
                                               regs_q[addr_nxt[IDX_W-1:0]] : '0;
                                    first_d  = 1'b1;
                                    state_d  = StData;
                                end
                            end
                        end
                        StData: begin
                            if (sclk_rise) begin
                                shift_d = shift_nxt;
                                cnt_d   = cnt_q + CNT_W'(1);
                                if (cnt_q == CNT_LAST) begin
                                    state_d = StDone;
                                end
                            end else if (sclk_fall) begin
                                // First fall presents the MSB; later falls advance.
                                if (first_q) begin
                                    cipo_d  = shadow_q[DATA_W-1];
                                    first_d = 1'b0;
                                end else begin
                                    shadow_d = shadow_shl;
                                    cipo_d   = shadow_shl[DATA_W-1];
                                end
                            end
                        end
                        StDone: begin
                            if (sclk_rise) begin
                                overrun_d = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StWaitHi;
            sclk_sync_q <= '0;
            ncs_sync_q  <= '1;
            copi_sync_q <= '0;
            sclk_dly_q  <= 1'b0;
            ncs_dly_q   <= 1'b1;
            flush_q     <= '0;
            cnt_q       <= '0;
            shift_q     <= '0;
            shadow_q    <= '0;
            first_q     <= 1'b0;
            overrun_q   <= 1'b0;
            cipo_q      <= 1'b0;
            cipo_oe_q   <= 1'b0;
            wr_pulse_q  <= 1'b0;
            wr_addr_q   <= '0;
            err_q       <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            ncs_sync_q  <= ncs_sync_d;
            copi_sync_q <= copi_sync_d;
            sclk_dly_q  <= sclk_dly_d;
            ncs_dly_q   <= ncs_dly_d;
            flush_q     <= flush_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            shadow_q    <= shadow_d;
            first_q     <= first_d;
            overrun_q   <= overrun_d;
            cipo_q      <= cipo_d;
            cipo_oe_q   <= cipo_oe_d;
            wr_pulse_q  <= wr_pulse_d;
            wr_addr_q   <= wr_addr_d;
            err_q       <= err_d;
            regs_q      <= regs_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_out[g*DATA_W +: DATA_W] = regs_q[g];
    end

    assign cipo          = cipo_q;
    assign cipo_oe       = cipo_oe_q;
    assign wr_pulse      = wr_pulse_q;
    assign wr_addr       = wr_addr_q;
    assign frame_err_cnt = err_q;

endmodule

// File: tb/tb_spi_regfile_periph.sv
// Scoreboard bench for spi_regfile_periph at default parameters.
module tb_spi_regfile_periph;

    localparam int HALF = 5;

    logic        clk = 1'b0;
    logic        rst, sclk, ncs, copi;
    logic        cipo, cipo_oe, wr_pulse;
    logic [63:0] regs_out;
    logic [6:0]  wr_addr;
    logic [7:0]  frame_err_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [14:0] wr_q [$];
    logic [7:0]  rd_q [$];
    logic [14:0] wr_e;
    logic [7:0]  rd_e;
    logic [63:0] exp_regs;
    int          exp_err;
    logic [31:0] rx;

    spi_regfile_periph dut (
        .clk           (clk),
        .rst           (rst),
        .sclk          (sclk),
        .ncs           (ncs),
        .copi          (copi),
        .cipo          (cipo),
        .cipo_oe       (cipo_oe),
        .regs_out      (regs_out),
        .wr_pulse      (wr_pulse),
        .wr_addr       (wr_addr),
        .frame_err_cnt (frame_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Every wr_pulse cycle must consume exactly one expected commit.
    always @(negedge clk) begin
        if (!rst && wr_pulse) begin
            if (wr_q.size() == 0) begin
                check("unexpected_wr_pulse", 64'd1, 64'd0);
            end else begin
                wr_e = wr_q.pop_front();
                check("wr_addr", 64'(wr_addr), 64'(wr_e[14:8]));
                check("wr_data", 64'(regs_out[wr_e[10:8]*8 +: 8]), 64'(wr_e[7:0]));
            end
        end
    end

    task automatic send_bits(input int n, input logic [31:0] v);
        for (int i = 0; i < n; i++) begin
            copi = v[n-1-i];
            wait_clk(HALF);
            rx   = {rx[30:0], cipo};
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic frame(input int n, input logic [31:0] v);
        ncs = 1'b0;
        wait_clk(HALF);
        send_bits(n, v);
        wait_clk(HALF);
        check("cipo_oe_active", 64'(cipo_oe), 64'd1);
        ncs = 1'b1;
        wait_clk(10);
        check("cipo_oe_idle", 64'(cipo_oe), 64'd0);
        check("cipo_idle", 64'(cipo), 64'd0);
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        if (a < 7'd8) begin
            wr_q.push_back({a, d});
            exp_regs[a[2:0]*8 +: 8] = d;
        end
        frame(16, {16'h0, 1'b1, a, d});
    endtask

    task automatic rd(input logic [6:0] a, input logic [7:0] d);
        rd_q.push_back(d);
        frame(16, {16'h0, 1'b0, a, 8'h00});
        rd_e = rd_q.pop_front();
        check("rd_data", 64'(rx[7:0]), 64'(rd_e));
        check("rd_cmd_cipo", 64'(rx[15:8]), 64'd0);
    endtask

    task automatic err_frame(input int n, input logic [31:0] v);
        frame(n, v);
        if (exp_err < 255) exp_err++;
    endtask

    initial begin
        rst = 1'b1; sclk = 1'b0; ncs = 1'b1; copi = 1'b0; rx = '0;
        exp_regs = '0; exp_err = 0;
        wait_clk(4);
        check("rst_regs", regs_out, 64'd0);
        check("rst_wr_pulse", 64'(wr_pulse), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_err", 64'(frame_err_cnt), 64'd0);
        check("rst_cipo", 64'(cipo), 64'd0);
        check("rst_cipo_oe", 64'(cipo_oe), 64'd0);
        rst = 1'b0;
        wait_clk(10);

        wr(7'd3, 8'hA5);
        check("regs_after_wr3", regs_out, exp_regs);
        check("err_after_wr3", 64'(frame_err_cnt), 64'(exp_err));

        rd(7'd3, 8'hA5);
        check("regs_after_rd3", regs_out, exp_regs);

        err_frame(15, 32'h412A);
        err_frame(17, 32'h104AB);
        check("err_short_long", 64'(frame_err_cnt), 64'(exp_err));
        check("regs_after_bad", regs_out, exp_regs);

        wr(7'd9, 8'h3C);
        check("regs_after_wr9", regs_out, exp_regs);
        check("err_after_wr9", 64'(frame_err_cnt), 64'(exp_err));
        rd(7'd9, 8'h00);

        // Reset in the middle of a write to reg 1; the tail must be ignored.
        ncs = 1'b0;
        wait_clk(HALF);
        send_bits(8, 32'h81);
        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        exp_regs = '0;
        exp_err  = 0;
        send_bits(8, 32'h5A);
        wait_clk(HALF);
        ncs = 1'b1;
        wait_clk(10);
        check("regs_after_midrst", regs_out, exp_regs);
        check("err_after_midrst", 64'(frame_err_cnt), 64'(exp_err));
        wr(7'd1, 8'h5A);
        check("regs_after_wr1", regs_out, exp_regs);

        err_frame(15, 32'h412A);
        check("err_first", 64'(frame_err_cnt), 64'(exp_err));
        for (int i = 1; i < 256; i++) begin
            err_frame(15, 32'h412A);
        end
        check("err_sat", 64'(frame_err_cnt), 64'(exp_err));
        err_frame(15, 32'h412A);
        check("err_hold", 64'(frame_err_cnt), 64'(exp_err));
        check("regs_final", regs_out, exp_regs);

        wait_clk(5);
        check("wr_q_empty", 64'(wr_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
